// File: rtl/pc_pkg.sv
// Shared definitions for the PC/next-PC stage: condition codes, NZCV bit positions
// and the flag register type.
package pc_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/pc_next_unit_if.sv
// Control/data bundle between the decoder/datapath and the PC stage.
// Optional PC_BRANCH_STATS_EN adds the takenCount/branchCount counter outputs.
interface pc_next_unit_if
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
);
    logic              stall;
    logic [31:0]       instr;
    logic              uncondBranch;
    logic              cbBranch;
    logic              cbzBranch;
    logic              setPCReg;
    logic              link;
    logic [ADDR_W-1:0] regData;
    flags_t            aluFlags;
    logic              setFlags;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] linkAddr;
    logic              branchTaken;
    flags_t            flags;
`ifdef PC_BRANCH_STATS_EN
    logic [31:0]       takenCount;
    logic [31:0]       branchCount;
`endif

    modport master (
        output stall, instr, uncondBranch, cbBranch, cbzBranch, setPCReg, link,
               regData, aluFlags, setFlags,
`ifdef PC_BRANCH_STATS_EN
        input  takenCount, branchCount,
`endif
        input  pc, linkAddr, branchTaken, flags
    );

    modport slave (
        input  stall, instr, uncondBranch, cbBranch, cbzBranch, setPCReg, link,
               regData, aluFlags, setFlags,
`ifdef PC_BRANCH_STATS_EN
        output takenCount, branchCount,
`endif
        output pc, linkAddr, branchTaken, flags
    );

endinterface

// File: rtl/pc_next_unit_cond_eval.sv
// B.cond evaluator: decides whether a condition code holds for the given NZCV flags.
module cond_eval
    import pc_pkg::*;
(
    input  logic [3:0] cond,
    input  flags_t     flags,
    output logic       taken
);

    logic w_n, w_z, w_v;
    logic w_unused_c;

    assign w_n        = flags[FLAG_N];
    assign w_z        = flags[FLAG_Z];
    assign w_v        = flags[FLAG_V];
    assign w_unused_c = flags[FLAG_C];

    // Codes outside the supported subset are never taken.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = w_z;
            COND_NE: taken = !w_z;
            COND_GE: taken = (w_n == w_v);
            COND_LT: taken = (w_n != w_v);
            COND_GT: taken = !w_z && (w_n == w_v);
            COND_LE: taken = w_z || (w_n != w_v);
            COND_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_next_unit.sv
// Fetch-side PC stage: holds PC and NZCV, selects the next PC from branch decode.
// Optional PC_BRANCH_STATS_EN adds saturating branch/taken counters.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
)(
    input  logic                  clk,
    input  logic                  reset,
    pc_next_unit_if.slave         bus
);

    logic [ADDR_W-1:0] r_pc;
    flags_t            r_flags;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_imm26_off;
    logic [ADDR_W-1:0] w_imm19_off;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_cond_taken;
    logic              w_branch_taken;
    logic              w_unused;

    assign w_unused = ^{bus.link, bus.instr[31:26], bus.instr[4]};

    // Word offsets, sign-extended to the PC width.
    assign w_pc_plus4  = r_pc + ADDR_W'(4);
    assign w_imm26_off = {{(ADDR_W-28){bus.instr[25]}}, bus.instr[25:0], 2'b00};
    assign w_imm19_off = {{(ADDR_W-21){bus.instr[23]}}, bus.instr[23:5], 2'b00};

    // Condition sees the committed flag register, not this cycle's ALU flags.
    cond_eval u_cond_eval (
        .cond  (bus.instr[3:0]),
        .flags (r_flags),
        .taken (w_cond_taken)
    );

    // Fixed priority resolves illegal multi-asserted decodes.
    always_comb begin
        w_next_pc      = w_pc_plus4;
        w_branch_taken = 1'b0;
        if (bus.setPCReg) begin
            w_next_pc      = bus.regData;
            w_branch_taken = 1'b1;
        end else if (bus.uncondBranch) begin
            w_next_pc      = r_pc + w_imm26_off;
            w_branch_taken = 1'b1;
        end else if (bus.cbzBranch && (bus.regData == '0)) begin
            w_next_pc      = r_pc + w_imm19_off;
            w_branch_taken = 1'b1;
        end else if (bus.cbBranch && w_cond_taken) begin
            w_next_pc      = r_pc + w_imm19_off;
            w_branch_taken = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_flags <= '0;
        end else if (!bus.stall) begin
            r_pc <= w_next_pc;
            if (bus.setFlags) begin
                r_flags <= bus.aluFlags;
            end
        end
    end

    assign bus.pc          = r_pc;
    assign bus.flags       = r_flags;
    assign bus.linkAddr    = w_pc_plus4;
    assign bus.branchTaken = w_branch_taken;

`ifdef PC_BRANCH_STATS_EN
    logic [31:0] r_taken_count;
    logic [31:0] r_branch_count;
    logic        w_any_branch;

    assign w_any_branch = bus.uncondBranch | bus.cbBranch | bus.cbzBranch | bus.setPCReg;

    // Counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_taken_count  <= '0;
            r_branch_count <= '0;
        end else if (!bus.stall) begin
            if (w_any_branch && (r_branch_count != 32'hFFFF_FFFF)) begin
                r_branch_count <= r_branch_count + 32'd1;
            end
            if (w_branch_taken && (r_taken_count != 32'hFFFF_FFFF)) begin
                r_taken_count <= r_taken_count + 32'd1;
            end
        end
    end

    assign bus.takenCount  = r_taken_count;
    assign bus.branchCount = r_branch_count;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed self-checking bench for pc_next_unit; expected values are hand-computed.
module tb_pc_next_unit;
    import pc_pkg::*;

    localparam int unsigned ADDR_W = 64;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    pc_next_unit_if #(.ADDR_W(ADDR_W)) bus_if ();

    pc_next_unit #(.ADDR_W(ADDR_W), .RESET_PC(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        bus_if.uncondBranch = 1'b0;
        bus_if.cbBranch     = 1'b0;
        bus_if.cbzBranch    = 1'b0;
        bus_if.setPCReg     = 1'b0;
        bus_if.link         = 1'b0;
        bus_if.setFlags     = 1'b0;
        bus_if.instr        = 32'h0;
        bus_if.regData      = 64'h0;
    endtask

    // BR to an absolute address to position the PC for the next scenario.
    task automatic jump_to(input logic [63:0] addr);
        clear_ctl();
        bus_if.setPCReg = 1'b1;
        bus_if.regData  = addr;
        step();
        clear_ctl();
        check("jump_pc", bus_if.pc, addr);
    endtask

    logic [3:0] cond_codes [8];
    logic       cond_exp   [8];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus_if.stall    = 1'b0;
        bus_if.aluFlags = 4'b0000;
        clear_ctl();

        // Reset and sequential fetch
        step();
        step();
        check("reset_pc", bus_if.pc, 64'h0);
        check("reset_flags", 64'(bus_if.flags), 64'h0);
        check("reset_taken", 64'(bus_if.branchTaken), 64'h0);
        reset = 1'b0;
        check("seq_pc0", bus_if.pc, 64'h0);
        check("seq_link0", bus_if.linkAddr, 64'h4);
        step();
        check("seq_pc4", bus_if.pc, 64'h4);
        step();
        check("seq_pc8", bus_if.pc, 64'h8);

        // BL with negative imm26
        jump_to(64'h40);
        bus_if.uncondBranch = 1'b1;
        bus_if.link         = 1'b1;
        bus_if.instr        = 32'h97FF_FFFE;
        #1;
        check("bl_taken", 64'(bus_if.branchTaken), 64'h1);
        check("bl_link", bus_if.linkAddr, 64'h44);
        step();
        clear_ctl();
        check("bl_pc", bus_if.pc, 64'h38);

        // Flags set a cycle ahead of B.cond; ALU flags at branch time must be ignored
        jump_to(64'hFC);
        bus_if.setFlags = 1'b1;
        bus_if.aluFlags = 4'b1000;
        step();
        clear_ctl();
        bus_if.aluFlags = 4'b0000;
        check("subs_flags", 64'(bus_if.flags), 64'h8);
        check("subs_pc", bus_if.pc, 64'h100);
        bus_if.cbBranch = 1'b1;
        bus_if.instr    = 32'h5400_0000 | (32'd3 << 5) | 32'(COND_LT);
        #1;
        check("blt_taken", 64'(bus_if.branchTaken), 64'h1);
        step();
        clear_ctl();
        check("blt_pc", bus_if.pc, 64'h10C);

        jump_to(64'h100);
        bus_if.cbBranch = 1'b1;
        bus_if.instr    = 32'h5400_0000 | (32'd3 << 5) | 32'(COND_GE);
        #1;
        check("bge_taken", 64'(bus_if.branchTaken), 64'h0);
        step();
        clear_ctl();
        check("bge_pc", bus_if.pc, 64'h104);

        // Condition table against flags N=1 Z=0 C=0 V=0
        cond_codes[0] = COND_EQ; cond_exp[0] = 1'b0;
        cond_codes[1] = COND_NE; cond_exp[1] = 1'b1;
        cond_codes[2] = COND_GE; cond_exp[2] = 1'b0;
        cond_codes[3] = COND_LT; cond_exp[3] = 1'b1;
        cond_codes[4] = COND_GT; cond_exp[4] = 1'b0;
        cond_codes[5] = COND_LE; cond_exp[5] = 1'b1;
        cond_codes[6] = COND_AL; cond_exp[6] = 1'b1;
        cond_codes[7] = 4'b0011; cond_exp[7] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_if.cbBranch = 1'b1;
            bus_if.instr    = 32'h5400_0020 | 32'(cond_codes[i]);
            #1;
            check($sformatf("cond_%b", cond_codes[i]), 64'(bus_if.branchTaken), 64'(cond_exp[i]));
        end
        clear_ctl();

        // CBZ taken and not taken
        jump_to(64'h20);
        bus_if.cbzBranch = 1'b1;
        bus_if.instr     = 32'hB400_0000 | (32'd5 << 5);
        bus_if.regData   = 64'h0;
        #1;
        check("cbz0_taken", 64'(bus_if.branchTaken), 64'h1);
        step();
        clear_ctl();
        check("cbz0_pc", bus_if.pc, 64'h34);

        jump_to(64'h20);
        bus_if.cbzBranch = 1'b1;
        bus_if.instr     = 32'hB400_0000 | (32'd5 << 5);
        bus_if.regData   = 64'h1;
        #1;
        check("cbz1_taken", 64'(bus_if.branchTaken), 64'h0);
        step();
        clear_ctl();
        check("cbz1_pc", bus_if.pc, 64'h24);

`ifdef PC_BRANCH_STATS_EN
        check("stat_branch", 64'(bus_if.branchCount), 64'd10);
        check("stat_taken", 64'(bus_if.takenCount), 64'd8);
`endif

        // BR wins over B; then stall holds PC and flags
        bus_if.setPCReg     = 1'b1;
        bus_if.uncondBranch = 1'b1;
        bus_if.regData      = 64'h1000;
        bus_if.instr        = 32'h17FF_FFFE;
        step();
        clear_ctl();
        check("prio_pc", bus_if.pc, 64'h1000);
        bus_if.stall    = 1'b1;
        bus_if.setFlags = 1'b1;
        bus_if.aluFlags = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", bus_if.pc, 64'h1000);
            check("stall_flags", 64'(bus_if.flags), 64'h8);
        end
        check("stall_link", bus_if.linkAddr, 64'h1004);
        bus_if.stall = 1'b0;
        clear_ctl();

        // Reset during stall still loads RESET_PC
        jump_to(64'h80);
        bus_if.stall = 1'b1;
        reset        = 1'b1;
        step();
        check("rst_stall_pc", bus_if.pc, 64'h0);
        check("rst_stall_flags", 64'(bus_if.flags), 64'h0);
`ifdef PC_BRANCH_STATS_EN
        check("rst_branch_cnt", 64'(bus_if.branchCount), 64'd0);
        check("rst_taken_cnt", 64'(bus_if.takenCount), 64'd0);
`endif
        reset        = 1'b0;
        bus_if.stall = 1'b0;
        step();
        check("post_rst_pc", bus_if.pc, 64'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
